conv_down_pipe: RTL and testbench

- Parametrised width down-converter: takes IN_W-bit words and emits them as OUT_W-bit segments, LSB segment first.
- Segments per word are runtime-selectable through MODE, which generalises the fixed 32-to-8 converter.
- Adds valid/ready handshakes on both sides, an enable freeze and back-to-back word acceptance.
- Sits between the PIPE-side wide datapath and the byte-serial PHY lane logic.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_seg_mux.sv | 23 ++
 rtl/conv_down_pipe.sv | 95 +++++++++
 tb/tb_conv_down_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the width down-converter: state encoding, clog2 and
// parameter legality helper.
package conv_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // IN_W must split into a power-of-two count (>= 2) of OUT_W segments.
  function automatic bit widths_legal(input int in_w, input int out_w);
    int ratio;
    if (out_w <= 0 || in_w <= 0) return 1'b0;
    if (in_w % out_w != 0) return 1'b0;
    ratio = in_w / out_w;
    return (ratio >= 2) && ((ratio & (ratio - 1)) == 0);
  endfunction

endpackage

// File: rtl/conv_seg_mux.sv
// Combinational selector: returns segment idx (OUT_W bits, 0 = LSB) of an
// IN_W-bit word.
module conv_seg_mux
  import conv_pkg::*;
#(
  parameter int  IN_W  = 32,
  parameter int  OUT_W = 8,
  localparam int RATIO = IN_W / OUT_W,
  localparam int CW    = clog2(RATIO)
) (
  input  logic [IN_W-1:0]  word,
  input  logic [CW-1:0]    idx,
  output logic [OUT_W-1:0] seg
);

  always_comb begin
    seg = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx == CW'(i)) seg = word[i*OUT_W +: OUT_W];
    end
  end

endmodule

// File: rtl/conv_down_pipe.sv
// Width down-converter: captures IN_W-bit words and emits MODE+1 OUT_W-bit
// segments per word, LSB first, with back-to-back word acceptance.
module conv_down_pipe
  import conv_pkg::*;
#(
  parameter int  IN_W  = 32,
  parameter int  OUT_W = 8,
  localparam int RATIO = IN_W / OUT_W,
  localparam int CW    = clog2(RATIO)
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic [CW-1:0]    MODE,
  input  logic [IN_W-1:0]  IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [OUT_W-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CW-1:0]    OUT_IDX,
  output logic             OUT_LAST,
  output state_t           dbg_state
);

  if (!widths_legal(IN_W, OUT_W)) begin : g_bad_params
    $error("conv_down_pipe: IN_W must be a power-of-two multiple (>=2) of OUT_W");
  end

  state_t            state, state_nxt;
  logic [IN_W-1:0]   hold_q, hold_nxt;
  logic [CW-1:0]     idx_q, idx_nxt;
  logic [CW-1:0]     nseg_q, nseg_nxt;
  logic              shifting, last, in_xfer, out_xfer;
  logic [OUT_W-1:0]  seg;

  conv_seg_mux #(.IN_W(IN_W), .OUT_W(OUT_W)) u_seg_mux (
    .word (hold_q),
    .idx  (idx_q),
    .seg  (seg)
  );

  assign shifting  = (state == ST_SHIFT);
  assign last      = shifting && (idx_q == nseg_q);
  assign OUT_VALID = shifting;
  assign OUT_LAST  = last;
  assign OUT_IDX   = shifting ? idx_q : '0;
  assign OUT_DATA  = shifting ? seg : '0;
  assign dbg_state = state;

  // Handshakes: a transfer happens on a rising CLK edge when valid, ready and
  // ENB are all high. IN_READY depends only on state, ENB and OUT_READY (never
  // on IN_VALID), so a new word can be taken in the same cycle the last
  // segment of the previous one leaves. OUT_VALID never drops without a
  // transfer.
  assign IN_READY = RESET_L && ENB && (!shifting || (OUT_READY && last));
  assign in_xfer  = IN_VALID && IN_READY;
  assign out_xfer = shifting && OUT_READY && ENB;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state  <= ST_IDLE;
      hold_q <= '0;
      idx_q  <= '0;
      nseg_q <= '0;
    end else begin
      state  <= state_nxt;
      hold_q <= hold_nxt;
      idx_q  <= idx_nxt;
      nseg_q <= nseg_nxt;
    end
  end

  // MODE is only looked at on capture, so changing it mid-word is harmless.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    idx_nxt   = idx_q;
    nseg_nxt  = nseg_q;
    if (in_xfer) begin
      state_nxt = ST_SHIFT;
      hold_nxt  = IN_DATA;
      idx_nxt   = '0;
      nseg_nxt  = MODE;
    end else if (out_xfer) begin
      if (last) begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end else begin
        idx_nxt = idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_down_pipe.sv
// Bench for conv_down_pipe: queue-based segment model checked every cycle,
// plus directed scenarios with literal expected segment sequences.
module tb_conv_down_pipe;
  import conv_pkg::*;

  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int CW    = 2;
  localparam int E_W   = 1 + CW + OUT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enb = 1'b0;
  logic [CW-1:0]    mode = '0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_idx;
  logic             out_last;
  state_t           dbg_state;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: the segments still to be emitted for the word in flight, as
  // {last, idx, data}. Empty means the converter is idle.
  logic [E_W-1:0]   mq[$];
  logic [E_W-1:0]   exp_q[$];
  logic [E_W-1:0]   got_q[$];
  int               got_cyc[$];
  logic [OUT_W-1:0] rdy_q[$];
  logic [E_W-1:0]   head_e;
  logic             model_rdy;

  conv_down_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .CLK       (clk),
    .RESET_L   (rst_n),
    .ENB       (enb),
    .MODE      (mode),
    .IN_DATA   (in_data),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .OUT_DATA  (out_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_IDX   (out_idx),
    .OUT_LAST  (out_last),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #90000;
    $display("FAIL watchdog: run did not finish, got running, required finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [E_W-1:0] ent(input logic l, input logic [CW-1:0] i,
                                         input logic [OUT_W-1:0] d);
    return {l, i, d};
  endfunction

  function automatic logic model_in_ready();
    return rst_n && enb && (mq.size() == 0 || (mq.size() == 1 && out_ready));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (enb) begin
      model_rdy = model_in_ready();
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (in_valid && model_rdy) begin
        for (int k = 0; k <= int'(mode); k++)
          mq.push_back({k == int'(mode), CW'(k), in_data[k*OUT_W +: OUT_W]});
      end
    end
  end

  // ---------------- compare (every cycle, away from the active edge) ----------------
  always @(negedge clk) begin
    head_e = (mq.size() != 0) ? mq[0] : '0;
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("in_ready", 32'(in_ready), 32'(model_in_ready()));
    check("out_data", 32'(out_data), 32'(head_e[OUT_W-1:0]));
    check("out_idx", 32'(out_idx), 32'(head_e[OUT_W +: CW]));
    check("out_last", 32'(out_last), 32'(head_e[E_W-1]));
    check("state", 32'(dbg_state), 32'(mq.size() != 0));
    if (out_valid && out_ready && enb && rst_n) begin
      got_q.push_back({out_last, out_idx, out_data});
      got_cyc.push_back(cyc);
    end
    if (in_ready && out_valid) rdy_q.push_back(out_data);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic [CW-1:0] m);
    logic acc;
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      acc = in_ready && enb;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (!out_valid) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    rdy_q.delete();
    exp_q.delete();
  endtask

  task automatic check_seq(input string name);
    check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check(name, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    out_ready = 1'b1;
    enb       = 1'b1;
    rst_n     = 1'b0;
    step(2);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Single word, four segments.
    clear_logs();
    send(32'hA1B2C3D4, 2'd3);
    wait_idle();
    exp_q = '{ent(1'b0, 2'd0, 8'hD4), ent(1'b0, 2'd1, 8'hC3),
              ent(1'b0, 2'd2, 8'hB2), ent(1'b1, 2'd3, 8'hA1)};
    check_seq("t1_seq");
    check("t1_contig", (got_cyc.size() == 4) ? 32'(got_cyc[3] - got_cyc[0]) : 32'hFFFF, 32'd3);

    // Two words back-to-back, no bubble between them.
    clear_logs();
    send(32'h04030201, 2'd3);
    send(32'h08070605, 2'd3);
    wait_idle();
    for (int k = 0; k < 8; k++)
      exp_q.push_back(ent(k % 4 == 3, CW'(k % 4), OUT_W'(k + 1)));
    check_seq("t2_seq");
    check("t2_contig", (got_cyc.size() == 8) ? 32'(got_cyc[7] - got_cyc[0]) : 32'hFFFF, 32'd7);
    check("t2_rdy_cnt", 32'(rdy_q.size()), 32'd2);
    check("t2_rdy_first", (rdy_q.size() > 0) ? 32'(rdy_q[0]) : 32'hFFFF, 32'h04);
    check("t2_rdy_second", (rdy_q.size() > 1) ? 32'(rdy_q[1]) : 32'hFFFF, 32'h08);

    // Two-segment word; MODE change mid-word must not matter.
    clear_logs();
    send(32'hDEADBEEF, 2'd1);
    mode = 2'd3;
    wait_idle();
    exp_q = '{ent(1'b0, 2'd0, 8'hEF), ent(1'b1, 2'd1, 8'hBE)};
    check_seq("t3_seq");

    // Backpressure while idx 1 is on the bus.
    clear_logs();
    send(32'h11223344, 2'd3);
    step(1);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t4_hold_data", 32'(out_data), 32'h33);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_idx", 32'(out_idx), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_idle();
    exp_q = '{ent(1'b0, 2'd0, 8'h44), ent(1'b0, 2'd1, 8'h33),
              ent(1'b0, 2'd2, 8'h22), ent(1'b1, 2'd3, 8'h11)};
    check_seq("t4_seq");

    // Enable freeze mid-word.
    clear_logs();
    send(32'h0D0C0B0A, 2'd3);
    step(1);
    enb = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t5_in_ready", 32'(in_ready), 32'd0);
      check("t5_data", 32'(out_data), 32'h0B);
      check("t5_idx", 32'(out_idx), 32'd1);
      check("t5_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    enb = 1'b1;
    wait_idle();
    exp_q = '{ent(1'b0, 2'd0, 8'h0A), ent(1'b0, 2'd1, 8'h0B),
              ent(1'b0, 2'd2, 8'h0C), ent(1'b1, 2'd3, 8'h0D)};
    check_seq("t5_seq");

    // Asynchronous reset at idx 2 drops the rest of the word.
    clear_logs();
    send(32'hA1B2C3D4, 2'd3);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data", 32'(out_data), 32'd0);
    check("t6_idx", 32'(out_idx), 32'd0);
    check("t6_last", 32'(out_last), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    step(2);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_post_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    exp_q = '{ent(1'b0, 2'd0, 8'hD4), ent(1'b0, 2'd1, 8'hC3)};
    check_seq("t6_seq");

    // MODE=0: one segment per word at one word per cycle.
    clear_logs();
    send(32'hFFFFFF55, 2'd0);
    send(32'hEEEEEE66, 2'd0);
    wait_idle();
    exp_q = '{ent(1'b1, 2'd0, 8'h55), ent(1'b1, 2'd0, 8'h66)};
    check_seq("t7_seq");
    check("t7_contig", (got_cyc.size() == 2) ? 32'(got_cyc[1] - got_cyc[0]) : 32'hFFFF, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
